// File: rtl/first_nios2_system_sysid_checker.sv
// Avalon-MM read master that reads the system-ID slave (word 0 = ID, word 1 = timestamp)
// and flags whether the hardware build matches the expected software build.
module first_nios2_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_1234,
    parameter logic [31:0] EXPECTED_TS    = 32'h50AE_2FFE,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        LAT_ID,
        RD_TS,
        LAT_TS,
        FIN
    } state_t;

    localparam logic [1:0]  LAT_LAST  = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic        r_auto_pend;
    logic [15:0] r_wait_cnt;
    logic [1:0]  r_lat_cnt;
    logic        r_read;
    logic        r_address;
    logic        r_busy;
    logic        r_done;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    logic w_is_id;
    logic w_accept;
    logic w_lat_last;
    logic w_capture;

    assign w_is_id    = (r_state == RD_ID) || (r_state == LAT_ID);
    assign w_accept   = ((r_state == RD_ID) || (r_state == RD_TS)) && !waitrequest;
    assign w_lat_last = ((r_state == LAT_ID) || (r_state == LAT_TS)) && (r_lat_cnt == LAT_LAST);
    // Zero-latency data arrives with the accept; otherwise on the last latency cycle.
    assign w_capture  = (READ_LATENCY == 0) ? w_accept : w_lat_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_auto_pend <= AUTO_START;
            r_wait_cnt  <= '0;
            r_lat_cnt   <= '0;
            r_read      <= 1'b0;
            r_address   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_id_ok     <= 1'b0;
            r_ts_ok     <= 1'b0;
            r_timeout   <= 1'b0;
            r_id_value  <= '0;
            r_ts_value  <= '0;
        end else begin
            // NOTE: done defaults low every cycle, so it can only ever be a one-cycle pulse.
            r_done <= 1'b0;

            if (w_capture) begin
                if (w_is_id) begin
                    r_id_value <= readdata;
                    r_id_ok    <= (readdata == EXPECTED_ID);
                end else begin
                    r_ts_value <= readdata;
                    r_ts_ok    <= (readdata == EXPECTED_TS);
                end
            end

            case (r_state)
                IDLE: begin
                    if (start || r_auto_pend) begin
                        r_auto_pend <= 1'b0;
                        r_state     <= RD_ID;
                        r_read      <= 1'b1;
                        r_address   <= 1'b0;
                        r_busy      <= 1'b1;
                        r_wait_cnt  <= '0;
                        r_id_ok     <= 1'b0;
                        r_ts_ok     <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_id_value  <= '0;
                        r_ts_value  <= '0;
                    end
                end
                RD_ID, RD_TS: begin
                    if (waitrequest) begin
                        // Stall limit reached: abandon the transfer and skip any remaining read.
                        if (r_wait_cnt == WAIT_LAST) begin
                            r_timeout  <= 1'b1;
                            r_wait_cnt <= '0;
                            r_state    <= FIN;
                            r_read     <= 1'b0;
                            r_address  <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 16'd1;
                        end
                    end else begin
                        r_wait_cnt <= '0;
                        if (READ_LATENCY != 0) begin
                            r_read    <= 1'b0;
                            r_address <= 1'b0;
                            r_lat_cnt <= '0;
                            r_state   <= w_is_id ? LAT_ID : LAT_TS;
                        end else if (w_is_id) begin
                            r_state   <= RD_TS;
                            r_address <= 1'b1;
                        end else begin
                            r_state   <= FIN;
                            r_read    <= 1'b0;
                            r_address <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end
                end
                LAT_ID, LAT_TS: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        if (w_is_id) begin
                            r_state   <= RD_TS;
                            r_read    <= 1'b1;
                            r_address <= 1'b1;
                        end else begin
                            r_state <= FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign address  = r_address;
    assign read     = r_read;
    assign busy     = r_busy;
    assign done     = r_done;
    assign id_ok    = r_id_ok;
    assign ts_ok    = r_ts_ok;
    assign timeout  = r_timeout;
    assign id_value = r_id_value;
    assign ts_value = r_ts_value;

endmodule
